// File: rtl/id_ex_pkg.sv
//==============================================================================
// Module : id_ex_pkg
// Brief  : Shared widths, control-bundle bit indices and payload struct for the
//          ID->EX pipeline register.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package id_ex_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 10;
  localparam int REG_W_DEF  = 5;

  // Control bundle layout: {AluOp[3:0], AluSrc, MemWrite, MemtoReg, MemRead, RegWrite, RegDst}
  localparam int REGDST_BIT   = 0;
  localparam int REGWRITE_BIT = 1;
  localparam int MEMREAD_BIT  = 2;
  localparam int MEMTOREG_BIT = 3;
  localparam int MEMWRITE_BIT = 4;
  localparam int ALUSRC_BIT   = 5;
  localparam int ALUOP_LSB    = 6;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] pc;
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [DATA_W_DEF-1:0] imm;
    logic [DATA_W_DEF-1:0] rd1;
    logic [DATA_W_DEF-1:0] rd2;
    logic [REG_W_DEF-1:0]  rs;
    logic [REG_W_DEF-1:0]  rt;
    logic [REG_W_DEF-1:0]  rd;
  } id_ex_payload_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_hazard_unit.sv
//==============================================================================
// Module : id_ex_hazard_unit
// Brief  : Load-use comparator; stalls ID while EX holds a load whose rt feeds
//          the incoming instruction. Only built under ID_EX_LOAD_USE_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_hazard_unit #(
  parameter int REG_W = 5
) (
  input  logic             in_valid,
  input  logic             out_valid,
  input  logic             memread_ex,
  input  logic             flush,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  output logic             hazard_stall
);

  logic rt_nonzero;
  logic rt_match;

  assign rt_nonzero = |rt_ex;
  assign rt_match   = (rt_ex == rs_id) | (rt_ex == rt_id);

  // A flush kills the load in EX, so there is nothing left to wait for.
  assign hazard_stall = in_valid & out_valid & memread_ex & rt_nonzero & rt_match & ~flush;

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
//==============================================================================
// Module : id_ex_pipe_reg
// Brief  : ID->EX pipeline register with valid/ready handshake, one skid entry,
//          synchronous flush and optional load-use stall (ID_EX_LOAD_USE_EN).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    pc_in,
  input  logic [CTRL_W-1:0]    ctrl_in,
  input  logic [DATA_W-1:0]    imm_in,
  input  logic [DATA_W-1:0]    rd1_in,
  input  logic [DATA_W-1:0]    rd2_in,
  input  logic [3*REG_W-1:0]   instr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    pc_out,
  output logic [DATA_W-1:0]    imm_out,
  output logic [DATA_W-1:0]    rd1_out,
  output logic [DATA_W-1:0]    rd2_out,
  output logic [CTRL_W-1:0]    ctrl_out,
  output logic [REG_W-1:0]     reg_rs_ex,
  output logic [REG_W-1:0]     reg_rt_ex,
  output logic [REG_W-1:0]     reg_rd_ex,
  output logic                 hazard_stall
);

  id_ex_payload_t main_q, main_d;
  id_ex_payload_t skid_q, skid_d;
  logic           main_valid_q, main_valid_d;
  logic           skid_valid_q, skid_valid_d;

  id_ex_payload_t in_payload;
  logic           accept;
  logic           main_free;

  assign in_payload.pc   = pc_in;
  assign in_payload.ctrl = ctrl_in;
  assign in_payload.imm  = imm_in;
  assign in_payload.rd1  = rd1_in;
  assign in_payload.rd2  = rd2_in;
  assign in_payload.rs   = instr_in[3*REG_W-1:2*REG_W];
  assign in_payload.rt   = instr_in[2*REG_W-1:REG_W];
  assign in_payload.rd   = instr_in[REG_W-1:0];

  assign in_ready  = ~skid_valid_q & ~hazard_stall;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // Skid drains first; in_ready is low while it is full, so no accept collides.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_payload;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_payload;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign pc_out    = main_q.pc;
  assign imm_out   = main_q.imm;
  assign rd1_out   = main_q.rd1;
  assign rd2_out   = main_q.rd2;
  assign reg_rs_ex = main_q.rs;
  assign reg_rt_ex = main_q.rt;
  assign reg_rd_ex = main_q.rd;
  // Bubbles carry no control so they can never write registers or memory.
  assign ctrl_out  = main_valid_q ? main_q.ctrl : '0;

`ifdef ID_EX_LOAD_USE_EN
  id_ex_hazard_unit #(
    .REG_W (REG_W)
  ) u_hazard (
    .in_valid     (in_valid),
    .out_valid    (out_valid),
    .memread_ex   (ctrl_out[MEMREAD_BIT]),
    .flush        (flush),
    .rt_ex        (reg_rt_ex),
    .rs_id        (in_payload.rs),
    .rt_id        (in_payload.rt),
    .hazard_stall (hazard_stall)
  );
`else
  assign hazard_stall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
//==============================================================================
// Module : tb_id_ex_pipe_reg
// Brief  : Directed self-checking bench for id_ex_pipe_reg (either build of
//          ID_EX_LOAD_USE_EN).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_id_ex_pipe_reg;

`ifdef ID_EX_LOAD_USE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, hazard_stall;
  logic [31:0] pc_in, imm_in, rd1_in, rd2_in, pc_out, imm_out, rd1_out, rd2_out;
  logic [9:0]  ctrl_in, ctrl_out;
  logic [14:0] instr_in;
  logic [4:0]  reg_rs_ex, reg_rt_ex, reg_rd_ex;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid;
  logic [31:0] seen_pc;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .pc_in(pc_in), .ctrl_in(ctrl_in), .imm_in(imm_in), .rd1_in(rd1_in), .rd2_in(rd2_in),
    .instr_in(instr_in), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .imm_out(imm_out), .rd1_out(rd1_out), .rd2_out(rd2_out),
    .ctrl_out(ctrl_out), .reg_rs_ex(reg_rs_ex), .reg_rt_ex(reg_rt_ex),
    .reg_rd_ex(reg_rd_ex), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [9:0] ctrl,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    in_valid = v;
    pc_in    = pc;
    ctrl_in  = ctrl;
    imm_in   = pc ^ 32'hFFFF_0000;
    rd1_in   = pc + 32'h1000;
    rd2_in   = pc + 32'h2000;
    instr_in = {rs, rt, rd};
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ctrl", ctrl_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_hazard", hazard_stall, 0);
    rst = 1'b0;

    // Streaming: one-cycle latency, no bubbles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 10'h003 + 10'(i << 6), 5'(i), 5'(i + 1), 5'(i + 2));
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_pc", pc_out, 32'h100 + 32'(4 * i));
      check("stream_ctrl", ctrl_out, 10'h003 + 10'(i << 6));
      check("stream_rd1", rd1_out, 32'h1100 + 32'(4 * i));
      check("stream_imm", imm_out, (32'h100 + 32'(4 * i)) ^ 32'hFFFF_0000);
      check("stream_rt", reg_rt_ex, 5'(i + 1));
      check("stream_rd", reg_rd_ex, 5'(i + 2));
    end
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_ctrl", ctrl_out, 0);

    // Back-pressure with skid
    drive(1'b1, 32'h200, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    check("bp_pc0", pc_out, 32'h200);
    drive(1'b1, 32'h204, 10'h003, 5'd1, 5'd2, 5'd3);
    out_ready = 1'b0;
    #1;
    check("bp_ready_before_skid", in_ready, 1);
    tick();
    check("bp_hold_pc", pc_out, 32'h200);
    check("bp_ready_low", in_ready, 0);
    drive(1'b1, 32'h208, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    check("bp_hold_pc2", pc_out, 32'h200);
    check("bp_ready_low2", in_ready, 0);
    tick();
    check("bp_hold_pc3", pc_out, 32'h200);
    check("bp_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("bp_skid_pc", pc_out, 32'h204);
    check("bp_skid_valid", out_valid, 1);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_next_pc", pc_out, 32'h208);
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    tick();
    check("bp_no_dup", out_valid, 0);

    // Flush with full skid and input presented
    out_ready = 1'b0;
    drive(1'b1, 32'h280, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    drive(1'b1, 32'h284, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    check("fl_skid_full", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 32'h300, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", ctrl_out, 0);
    check("fl_ready", in_ready, 1);
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    out_ready = 1'b1;
    tick();
    check("fl_skid_gone", out_valid, 0);

    // Flush with a genuine simultaneous accept
    out_ready = 1'b0;
    drive(1'b1, 32'h310, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    drive(1'b1, 32'h314, 10'h003, 5'd1, 5'd2, 5'd3);
    flush = 1'b1;
    #1;
    check("fl2_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    check("fl2_valid", out_valid, 0);
    tick();
    check("fl2_dropped", out_valid, 0);

    // Asynchronous reset mid-cycle with both entries full
    drive(1'b1, 32'h500, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    drive(1'b1, 32'h504, 10'h003, 5'd1, 5'd2, 5'd3);
    tick();
    check("ar_pre_valid", out_valid, 1);
    check("ar_pre_ready", in_ready, 0);
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ctrl", ctrl_out, 0);
    check("ar_ready", in_ready, 1);
    check("ar_pc", pc_out, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("ar_after_valid", out_valid, 0);

    // Load-use: lw rt=5 in EX, add rs=5 in ID
    drive(1'b1, 32'h400, 10'h02E, 5'd1, 5'd5, 5'd0);
    tick();
    check("lu_lw_pc", pc_out, 32'h400);
    check("lu_lw_ctrl", ctrl_out, 10'h02E);
    drive(1'b1, 32'h404, 10'h003, 5'd5, 5'd6, 5'd7);
    #1;
    check("lu_stall", hazard_stall, LU);
    check("lu_ready", in_ready, !LU);
    n_valid = 0;
    seen_pc = 32'h0;
    tick();
    check("lu_t1_valid", out_valid, !LU);
    check("lu_t1_stall", hazard_stall, 0);
    if (out_valid) begin n_valid++; seen_pc = pc_out; end
    in_valid = LU;
    tick();
    check("lu_t2_valid", out_valid, LU);
    if (out_valid) begin n_valid++; seen_pc = pc_out; end
    check("lu_add_pc", seen_pc, 32'h404);
    check("lu_add_once", n_valid, 1);
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    tick();

    // Load-use with rt=0 never stalls
    drive(1'b1, 32'h410, 10'h02E, 5'd1, 5'd0, 5'd0);
    tick();
    drive(1'b1, 32'h414, 10'h003, 5'd0, 5'd6, 5'd7);
    #1;
    check("lu0_stall", hazard_stall, 0);
    check("lu0_ready", in_ready, 1);
    tick();
    check("lu0_pc", pc_out, 32'h414);
    check("lu0_valid", out_valid, 1);
    drive(1'b0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
    tick();
    check("lu0_drain", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
